// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM stage: access-size codes, FSM state codes,
// writeback control bit positions and the alignment rule.
package mem_access_stage_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef logic [1:0] mem_state_t;
  localparam mem_state_t ST_IDLE = 2'd0;
  localparam mem_state_t ST_REQ  = 2'd1;
  localparam mem_state_t ST_RESP = 2'd2;
  localparam mem_state_t ST_DONE = 2'd3;

  // Bit positions inside the 3-bit WB field carried into MEM/WB
  localparam int WB_REG_WRITE  = 0;
  localparam int WB_MEM_TO_REG = 1;
  localparam int WB_PC_TO_REG  = 2;

  // Unused funct3 codes (011, 110, 111) behave as word accesses
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic mis;
    case (funct3[1:0])
      2'b00:   mis = 1'b0;
      2'b01:   mis = addr_lo[0];
      default: mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_stage_align.sv
// Byte-lane steering: store byte enables / replicated write data, and
// load lane selection with sign or zero extension.
module mem_lane_align
  import mem_access_stage_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_ext
);

  logic [31:0] lane_s;

  // Shift the addressed lane down to bit 0, then size and extend it
  always_comb begin
    lane_s = load_data >> {addr_lo, 3'b000};
    case (funct3)
      F3_B: begin
        be       = 4'b0001 << addr_lo;
        wdata    = {4{store_data[7:0]}};
        load_ext = {{24{lane_s[7]}}, lane_s[7:0]};
      end
      F3_BU: begin
        be       = 4'b0001 << addr_lo;
        wdata    = {4{store_data[7:0]}};
        load_ext = {24'd0, lane_s[7:0]};
      end
      F3_H: begin
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{store_data[15:0]}};
        load_ext = {{16{lane_s[15]}}, lane_s[15:0]};
      end
      F3_HU: begin
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{store_data[15:0]}};
        load_ext = {16'd0, lane_s[15:0]};
      end
      default: begin
        be       = 4'b1111;
        wdata    = store_data;
        load_ext = lane_s;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives a request/grant/response data bus, stalls the
// front of the pipe while an access is outstanding and bubbles MEM/WB.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] alu_ans_i,
  input  logic [31:0] rs2_data_i,
  input  logic [2:0]  WB_i,
  input  logic [4:0]  WBreg_i,
  input  logic [31:0] pc_add4_i,
  output logic [2:0]  WB_o,
  output logic [31:0] DM_o,
  output logic [31:0] alu_ans_o,
  output logic [4:0]  WBreg_o,
  output logic [31:0] pc_add4_o,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  mem_state_t  state_r, state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [31:0] addr_r, wdata_r, rdata_r;
  logic [3:0]  be_r;
  logic        we_r, err_r;
  logic        mem_op_s, mis_s, start_s, timeout_s;
  logic        capture_s, rcap_s, tmo_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_s, load_ext_s;

  assign mem_op_s  = mem_read_i | mem_write_i;
  assign mis_s     = mem_op_s & is_misaligned(funct3_i, alu_ans_i[1:0]);
  assign start_s   = mem_op_s & ~mis_s;
  assign timeout_s = (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

  // EX/MEM is frozen during a stall, so the live inputs also drive load extraction in DONE
  mem_lane_align u_align (
    .funct3     (funct3_i),
    .addr_lo    (alu_ans_i[1:0]),
    .store_data (rs2_data_i),
    .load_data  (rdata_r),
    .be         (be_s),
    .wdata      (wdata_s),
    .load_ext   (load_ext_s)
  );

  // Next-state decode for the bus handshake, including timeout abort
  always_comb begin
    state_s   = state_r;
    capture_s = 1'b0;
    rcap_s    = 1'b0;
    tmo_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_s   = ST_REQ;
          capture_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (dmem_gnt_i) begin
          if (we_r || dmem_rvalid_i) begin
            state_s = ST_DONE;
            rcap_s  = ~we_r & dmem_rvalid_i;
          end else begin
            state_s = ST_RESP;
          end
        end else if (timeout_s) begin
          state_s = ST_DONE;
          tmo_s   = 1'b1;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_RESP: begin
        if (dmem_rvalid_i) begin
          state_s = ST_DONE;
          rcap_s  = 1'b1;
        end else if (timeout_s) begin
          state_s = ST_DONE;
          tmo_s   = 1'b1;
        end else begin
          state_s = ST_RESP;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State, timeout counter, latched request fields and captured read data
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      addr_r  <= 32'd0;
      be_r    <= 4'd0;
      we_r    <= 1'b0;
      wdata_r <= 32'd0;
      rdata_r <= 32'd0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      if (state_s != state_r) begin
        cnt_r <= '0;
      end else if ((state_r == ST_REQ) || (state_r == ST_RESP)) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= '0;
      end
      if (capture_s) begin
        addr_r  <= {alu_ans_i[31:2], 2'b00};
        be_r    <= be_s;
        we_r    <= mem_write_i;
        wdata_r <= wdata_s;
      end
      if (rcap_s) begin
        rdata_r <= dmem_rdata_i;
      end
      // err_r is only ever set on entry to DONE and clears when DONE is left
      if (state_r != ST_DONE) begin
        err_r <= tmo_s;
      end else begin
        err_r <= 1'b0;
      end
    end
  end

  // Pipeline-facing controls; held quiet while reset is asserted
  always_comb begin
    stall_o    = 1'b0;
    misalign_o = 1'b0;
    WB_o       = 3'd0;
    DM_o       = 32'd0;
    if (!rst_i) begin
      WB_o = 3'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          misalign_o = mis_s;
          stall_o    = start_s;
          WB_o       = mem_op_s ? 3'd0 : WB_i;
        end
        ST_REQ, ST_RESP: begin
          stall_o = 1'b1;
          WB_o    = 3'd0;
        end
        ST_DONE: begin
          WB_o = err_r ? 3'd0 : WB_i;
          DM_o = (err_r || we_r) ? 32'd0 : load_ext_s;
        end
        default: begin
          WB_o = 3'd0;
        end
      endcase
    end
  end

  assign dmem_req_o   = (state_r == ST_REQ);
  assign dmem_we_o    = dmem_req_o & we_r;
  assign dmem_be_o    = dmem_req_o ? be_r : 4'd0;
  assign dmem_addr_o  = addr_r;
  assign dmem_wdata_o = wdata_r;
  assign bus_err_o    = err_r;

  assign alu_ans_o = alu_ans_i;
  assign WBreg_o   = WBreg_i;
  assign pc_add4_o = pc_add4_i;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed cases plus randomized
// memory operations compared against a byte-level reference model.
module tb_mem_access_stage;

  localparam int TMO = 64;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        mem_read_i, mem_write_i;
  logic [2:0]  funct3_i;
  logic [31:0] alu_ans_i, rs2_data_i, pc_add4_i;
  logic [2:0]  WB_i;
  logic [4:0]  WBreg_i;
  logic [2:0]  WB_o;
  logic [31:0] DM_o, alu_ans_o, pc_add4_o;
  logic [4:0]  WBreg_o;
  logic        stall_o, misalign_o, bus_err_o;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;

  int checks = 0;
  int errors = 0;

  mem_access_stage #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .funct3_i(funct3_i),
    .alu_ans_i(alu_ans_i), .rs2_data_i(rs2_data_i), .WB_i(WB_i), .WBreg_i(WBreg_i),
    .pc_add4_i(pc_add4_i), .WB_o(WB_o), .DM_o(DM_o), .alu_ans_o(alu_ans_o),
    .WBreg_o(WBreg_o), .pc_add4_o(pc_add4_o), .stall_o(stall_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o), .dmem_req_o(dmem_req_o),
    .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: access width in bytes, then per-byte rules
  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
    logic [3:0] be;
    int a, n;
    a = int'(addr[1:0]);
    n = nbytes(f3);
    be = 4'd0;
    for (int i = 0; i < 4; i++) be[i] = (i >= a) && (i < a + n);
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    int n;
    n = nbytes(f3);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rd);
    logic [31:0] raw, mask;
    int n;
    n = nbytes(f3);
    raw = rd >> (8 * int'(addr[1:0]));
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    raw = raw & mask;
    if (!f3[2] && n < 4 && raw[8*n-1]) raw = raw | ~mask;
    return raw;
  endfunction

  // One instruction through MEM; gdly/rdly are grant delay and grant-to-rvalid delay
  task automatic do_op(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rdat, input int gdly, input int rdly);
    logic [2:0] wb;
    logic       mis, tmo;
    int         last;
    wb = 3'($urandom_range(1, 7));
    @(negedge clk_i);
    mem_read_i = rd; mem_write_i = wr; funct3_i = f3; alu_ans_i = addr;
    rs2_data_i = wd; WB_i = wb; WBreg_i = 5'($urandom); pc_add4_i = $urandom;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = rdat;
    #1;
    mis = (rd | wr) && ((int'(addr[1:0]) % nbytes(f3)) != 0);
    if (!(rd | wr)) begin
      chk("pass_stall", 32'(stall_o), 32'd0);
      chk("pass_dm", DM_o, 32'd0);
      chk("pass_wb", 32'(WB_o), 32'(wb));
      chk("pass_alu", alu_ans_o, addr);
      chk("pass_reg", 32'(WBreg_o), 32'(WBreg_i));
      chk("pass_pc", pc_add4_o, pc_add4_i);
      return;
    end
    if (mis) begin
      chk("mis_pulse", 32'(misalign_o), 32'd1);
      chk("mis_stall", 32'(stall_o), 32'd0);
      chk("mis_req", 32'(dmem_req_o), 32'd0);
      chk("mis_wb", 32'(WB_o), 32'd0);
      @(negedge clk_i);
      mem_read_i = 1'b0; mem_write_i = 1'b0;
      #1;
      chk("mis_req_after", 32'(dmem_req_o), 32'd0);
      chk("mis_end", 32'(misalign_o), 32'd0);
      return;
    end
    // The IDLE cycle that latches the request already holds the pipe
    chk("idle_stall", 32'(stall_o), 32'd1);
    chk("idle_req", 32'(dmem_req_o), 32'd0);
    chk("idle_wb", 32'(WB_o), 32'd0);
    tmo  = (gdly >= TMO);
    last = tmo ? TMO - 1 : (wr ? gdly : gdly + rdly);
    for (int k = 0; k <= last; k++) begin
      @(negedge clk_i);
      dmem_gnt_i    = (k == gdly);
      dmem_rvalid_i = rd && (k == gdly + rdly);
      #1;
      chk("busy_stall", 32'(stall_o), 32'd1);
      chk("busy_wb", 32'(WB_o), 32'd0);
      chk("busy_req", 32'(dmem_req_o), 32'(k <= gdly));
      if (k <= gdly) begin
        chk("req_addr", dmem_addr_o, {addr[31:2], 2'b00});
        chk("req_be", 32'(dmem_be_o), 32'(m_be(f3, addr)));
        chk("req_we", 32'(dmem_we_o), 32'(wr));
        if (wr) chk("req_wdata", dmem_wdata_o, m_wdata(f3, wd));
      end
    end
    @(negedge clk_i);
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = ~rdat;
    #1;
    chk("done_stall", 32'(stall_o), 32'd0);
    chk("done_req", 32'(dmem_req_o), 32'd0);
    chk("done_buserr", 32'(bus_err_o), 32'(tmo));
    chk("done_wb", 32'(WB_o), tmo ? 32'd0 : 32'(wb));
    if (rd) chk("done_dm", DM_o, tmo ? 32'd0 : m_load(f3, addr, rdat));
    @(negedge clk_i);
    mem_read_i = 1'b0; mem_write_i = 1'b0;
    #1;
    chk("idle_buserr", 32'(bus_err_o), 32'd0);
    chk("idle_nostall", 32'(stall_o), 32'd0);
  endtask

  initial begin
    logic [2:0] f3;
    logic       rd, wr;
    logic [2:0] ld_codes [8];
    ld_codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    rst_i = 1'b0;
    mem_read_i = 1'b1; mem_write_i = 1'b0; funct3_i = 3'b010; alu_ans_i = 32'h100;
    rs2_data_i = 32'd0; WB_i = 3'd5; WBreg_i = 5'd1; pc_add4_i = 32'd4;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'd0;
    #12;
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_req", 32'(dmem_req_o), 32'd0);
    chk("rst_be", 32'(dmem_be_o), 32'd0);
    chk("rst_we", 32'(dmem_we_o), 32'd0);
    chk("rst_mis", 32'(misalign_o), 32'd0);
    chk("rst_buserr", 32'(bus_err_o), 32'd0);
    mem_read_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;

    do_op(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'd0, 0, 0);
    do_op(1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 32'h80FF_FF7F, 0, 3);
    do_op(1'b1, 1'b0, 3'b100, 32'h103, 32'd0, 32'h80FF_FF7F, 0, 3);
    do_op(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'd0, 1, 0);
    do_op(1'b1, 1'b0, 3'b101, 32'h202, 32'd0, 32'hABCD0000, 0, 1);
    do_op(1'b1, 1'b0, 3'b010, 32'h101, 32'd0, 32'd0, 0, 0);
    do_op(1'b1, 1'b0, 3'b001, 32'h1FE, 32'd0, 32'h8001_0000, 0, 0);
    do_op(1'b1, 1'b0, 3'b010, 32'h300, 32'd0, 32'h1111_2222, TMO + 4, 0);
    do_op(1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'd0, 32'd0, 0, 0);

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 2))
        0: begin rd = 1'b1; wr = 1'b0; f3 = ld_codes[$urandom_range(0, 7)]; end
        1: begin rd = 1'b0; wr = 1'b1; f3 = 3'($urandom_range(0, 2)); end
        default: begin rd = 1'b0; wr = 1'b0; f3 = 3'($urandom); end
      endcase
      do_op(rd, wr, f3, $urandom, $urandom, $urandom, $urandom_range(0, 4), $urandom_range(0, 4));
    end

    // Reset while waiting for read data, then confirm the access is abandoned
    @(negedge clk_i);
    mem_read_i = 1'b1; mem_write_i = 1'b0; funct3_i = 3'b010; alu_ans_i = 32'h400; WB_i = 3'd3;
    @(negedge clk_i);
    dmem_gnt_i = 1'b1;
    @(negedge clk_i);
    dmem_gnt_i = 1'b0;
    #1;
    chk("resp_stall", 32'(stall_o), 32'd1);
    chk("resp_req", 32'(dmem_req_o), 32'd0);
    rst_i = 1'b0;
    #1;
    chk("arst_stall", 32'(stall_o), 32'd0);
    chk("arst_req", 32'(dmem_req_o), 32'd0);
    chk("arst_we", 32'(dmem_we_o), 32'd0);
    chk("arst_be", 32'(dmem_be_o), 32'd0);
    chk("arst_wb", 32'(WB_o), 32'd0);
    chk("arst_dm", DM_o, 32'd0);
    chk("arst_buserr", 32'(bus_err_o), 32'd0);
    @(negedge clk_i);
    mem_read_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hFFFF_FFFF;
    @(negedge clk_i);
    rst_i = 1'b1; alu_ans_i = 32'h55AA_55AA; WB_i = 3'd6;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("post_req", 32'(dmem_req_o), 32'd0);
      chk("post_stall", 32'(stall_o), 32'd0);
      chk("post_dm", DM_o, 32'd0);
      chk("post_wb", 32'(WB_o), 32'd6);
      chk("post_alu", alu_ans_o, 32'h55AA_55AA);
      @(negedge clk_i);
    end
    dmem_rvalid_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
